// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSB first,
// tens-complement subtraction with sign/magnitude result.
// Ports: clk, rst (sync, active-high), start, op (0 add, 1 sub),
//   a/b packed BCD operands; result, sign, overflow, invalid,
//   busy (not IDLE), done (one-cycle pulse when result is valid).
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   result,
    output logic                  sign,
    output logic                  overflow,
    output logic                  invalid,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ADD   = 3'd2,
        COMP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_q, b_q, work, work_nxt;
    logic          op_q, carry;
    logic [IW-1:0] idx;
    logic [IW+1:0] pos;
    logic          last, bad;
    logic [3:0]    x, y, dig;
    logic [4:0]    s;
    logic          cout;

    assign pos  = {idx, 2'b00};
    assign last = (idx == IW'(DIGITS - 1));

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9)
                bad = 1'b1;
        end
    end

    // Shared digit adder: ADD sums A + B' + c, COMP sums (9 - d) + c.
    always_comb begin
        if (state == COMP) begin
            x = 4'd9 - work[pos +: 4];
            y = 4'd0;
        end else begin
            x = a_q[pos +: 4];
            y = op_q ? (4'd9 - b_q[pos +: 4]) : b_q[pos +: 4];
        end
        s = {1'b0, x} + {1'b0, y} + {4'd0, carry};
        if (s > 5'd9) begin
            dig  = s[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            dig  = s[3:0];
            cout = 1'b0;
        end
        work_nxt           = work;
        work_nxt[pos +: 4] = dig;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK:   state_nxt = bad ? DONE : ADD;
            ADD:     if (last) state_nxt = (op_q && !cout) ? COMP : DONE;
            COMP:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            work     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        idx   <= '0;
                        carry <= 1'b0;
                    end
                end
                CHECK: begin
                    // Subtraction is A + (99..9 - B) + 1.
                    carry <= op_q;
                    if (bad) begin
                        result   <= '0;
                        sign     <= 1'b0;
                        overflow <= 1'b0;
                        invalid  <= 1'b1;
                    end
                end
                ADD: begin
                    work  <= work_nxt;
                    carry <= cout;
                    idx   <= last ? '0 : idx + IW'(1);
                    if (last) begin
                        if (!op_q) begin
                            result   <= work_nxt;
                            overflow <= cout;
                            sign     <= 1'b0;
                            invalid  <= 1'b0;
                        end else if (cout) begin
                            result   <= work_nxt;
                            overflow <= 1'b0;
                            sign     <= 1'b0;
                            invalid  <= 1'b0;
                        end else begin
                            // No carry out: A < B, negate the sum.
                            carry <= 1'b1;
                        end
                    end
                end
                COMP: begin
                    work  <= work_nxt;
                    carry <= cout;
                    idx   <= last ? '0 : idx + IW'(1);
                    if (last) begin
                        result   <= work_nxt;
                        sign     <= 1'b1;
                        overflow <= 1'b0;
                        invalid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: 2- and 4-digit instances against an
// integer-arithmetic reference model, directed and random operations.
module tb_bcd_serial_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start2 = 1'b0;
    logic        start4 = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic [7:0]  result2;
    logic [15:0] result4;
    logic        sign2, overflow2, invalid2, busy2, done2;
    logic        sign4, overflow4, invalid4, busy4, done4;

    int          sel = 4;
    logic [15:0] o_result;
    logic        o_sign, o_ovf, o_inv, o_busy, o_done;

    int vectors = 0;
    int miscompares = 0;

    bcd_serial_addsub #(.DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op),
        .a(a[7:0]), .b(b[7:0]), .result(result2), .sign(sign2),
        .overflow(overflow2), .invalid(invalid2), .busy(busy2),
        .done(done2)
    );

    bcd_serial_addsub #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op),
        .a(a), .b(b), .result(result4), .sign(sign4),
        .overflow(overflow4), .invalid(invalid4), .busy(busy4),
        .done(done4)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel == 2) begin
            o_result = {8'h00, result2};
            o_sign   = sign2;
            o_ovf    = overflow2;
            o_inv    = invalid2;
            o_busy   = busy2;
            o_done   = done2;
        end else begin
            o_result = result4;
            o_sign   = sign4;
            o_ovf    = overflow4;
            o_inv    = invalid4;
            o_busy   = busy4;
            o_done   = done4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v, input int n);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: decode to integers, do plain decimal arithmetic.
    task automatic model(input int n, input logic o,
                         input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] r, output logic s,
                         output logic ov, output logic inv,
                         output int lat);
        int va, vb, p, da, db, m;
        va = 0; vb = 0; p = 1; inv = 1'b0;
        for (int i = 0; i < n; i++) begin
            da = int'(av[4*i +: 4]);
            db = int'(bv[4*i +: 4]);
            if (da > 9 || db > 9) inv = 1'b1;
            va += da * p;
            vb += db * p;
            p *= 10;
        end
        s = 1'b0; ov = 1'b0; m = 0;
        if (inv) begin
            lat = 2;
        end else if (!o) begin
            m   = (va + vb) % p;
            ov  = ((va + vb) >= p);
            lat = n + 2;
        end else if (va >= vb) begin
            m   = va - vb;
            lat = n + 2;
        end else begin
            m   = vb - va;
            s   = 1'b1;
            lat = 2 * n + 2;
        end
        r = inv ? 16'h0000 : to_bcd(m, n);
    endtask

    task automatic set_start(input int n, input logic v);
        if (n == 2) start2 = v;
        else        start4 = v;
    endtask

    task automatic run(input int n, input logic o,
                       input logic [15:0] av, input logic [15:0] bv,
                       input bit hold, input bit poke, input string tag);
        logic [15:0] er, prev;
        logic        es, eo, ei;
        int          el, j, extra;
        bit          seen, held;
        model(n, o, av, bv, er, es, eo, ei, el);
        sel = n;
        @(negedge clk);
        a = av; b = bv; op = o;
        set_start(n, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(n, 1'b0);
        a = 16'($urandom); b = 16'($urandom); op = ~o;
        prev = o_result;
        j = 0; seen = 0; held = 1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1;
                break;
            end
            if (o_result !== prev) held = 0;
            if (poke && j == 2) begin
                a = 16'h4444; b = 16'h3333;
                set_start(n, 1'b1);
            end
            if (poke && j == 3) set_start(n, 1'b0);
            @(posedge clk);
            j++;
        end
        chk({tag, "/done"}, 32'(seen), 32'd1);
        chk({tag, "/lat"}, 32'(j + 1), 32'(el));
        chk({tag, "/result"}, 32'(o_result), 32'(er));
        chk({tag, "/sign"}, 32'(o_sign), 32'(es));
        chk({tag, "/ovf"}, 32'(o_ovf), 32'(eo));
        chk({tag, "/inv"}, 32'(o_inv), 32'(ei));
        chk({tag, "/busy_done"}, 32'(o_busy), 32'd1);
        chk({tag, "/hold"}, 32'(held), 32'd1);
        @(negedge clk);
        chk({tag, "/pulse"}, 32'(o_done), 32'd0);
        chk({tag, "/idle"}, 32'(o_busy), 32'd0);
        if (hold) begin
            @(posedge clk);
            #1;
            set_start(n, 1'b0);
            @(negedge clk);
            chk({tag, "/restart"}, 32'(o_busy), 32'd1);
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (!o_busy) break;
            end
        end
        if (poke) begin
            extra = 0;
            for (int t = 0; t < 2 * n + 6; t++) begin
                @(negedge clk);
                if (o_done) extra++;
            end
            chk({tag, "/extra_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] av, bv;
        int          k, n, dn;
        logic        o;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst/result2", 32'(result2), 32'd0);
        chk("rst/flags2", 32'({sign2, overflow2, invalid2, busy2, done2}),
            32'd0);
        chk("rst/result4", 32'(result4), 32'd0);
        chk("rst/flags4", 32'({sign4, overflow4, invalid4, busy4, done4}),
            32'd0);
        rst = 1'b0;

        run(2, 1'b0, 16'h0047, 16'h0038, 0, 0, "add47_38");
        run(2, 1'b0, 16'h0099, 16'h0001, 0, 0, "add99_01");
        run(2, 1'b1, 16'h0025, 16'h0047, 0, 0, "sub25_47");
        run(2, 1'b1, 16'h0047, 16'h0047, 0, 0, "sub47_47");
        run(4, 1'b1, 16'h1000, 16'h0001, 0, 0, "sub1000_1");
        run(4, 1'b0, 16'h12A4, 16'h0000, 0, 0, "inv12A4");
        run(4, 1'b1, 16'h0000, 16'h9999, 0, 0, "sub0_9999");
        run(4, 1'b0, 16'h9999, 16'h9999, 0, 0, "add9999");
        run(4, 1'b0, 16'h1234, 16'h4321, 0, 1, "busy_start");
        run(4, 1'b0, 16'h0500, 16'h0505, 1, 0, "held_start");

        for (int r = 0; r < 60; r++) begin
            n  = (r % 2 == 0) ? 2 : 4;
            av = '0;
            bv = '0;
            for (int i = 0; i < n; i++) begin
                av[4*i +: 4] = 4'($urandom_range(0, 9));
                bv[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                k  = int'($urandom_range(0, n - 1));
                dn = int'($urandom_range(10, 15));
                if ($urandom_range(0, 1) == 0) av[4*k +: 4] = 4'(dn);
                else                           bv[4*k +: 4] = 4'(dn);
            end
            o = 1'($urandom_range(0, 1));
            run(n, o, av, bv, 0, 0, "rand");
        end

        run(4, 1'b0, 16'h9999, 16'h0002, 0, 0, "pre_rst");
        sel = 4;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; op = 1'b0;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst/result", 32'(result4), 32'd0);
        chk("midrst/flags", 32'({sign4, overflow4, invalid4, busy4, done4}),
            32'd0);
        rst = 1'b0;
        k = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (done4) k++;
        end
        chk("midrst/no_done", 32'(k), 32'd0);
        run(4, 1'b1, 16'h0321, 16'h4321, 0, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
